// File: rtl/mov8_sequencer_pkg.sv
// Shared relay-computer definitions: register codes, MOV8 FSM states and helpers.
package relay_pkg;

    typedef enum logic [2:0] {
        REG_A, REG_B, REG_C, REG_D, REG_M1, REG_M2, REG_X, REG_Y
    } reg_code_e;

    typedef enum logic [2:0] {
        ST_IDLE, ST_SELECT, ST_OPEN, ST_LATCH, ST_RELEASE, ST_DONE
    } mov8_state_e;

    localparam logic [1:0] OP_MOV8 = 2'b00;

    function automatic logic [7:0] onehot8(input reg_code_e code);
        return 8'h01 << code;
    endfunction

endpackage

// File: rtl/mov8_sequencer_phase_timer.sv
// Reloadable down-counter; expired is high while the count sits at zero.
module phase_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         expired
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= value;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/mov8_sequencer.sv
// MOV8 sequencer: steps the register sel/hold lines through select, open, latch, release.
module mov8_sequencer
    import relay_pkg::*;
#(
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] instr,
    output logic       busy,
    output logic       done,
    output logic       illegal,
    output logic [7:0] sel,
    output logic [7:0] hold,
    output logic       bus_clr
);

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE - 1);

    mov8_state_e state_q;
    reg_code_e   dst_q;
    logic        busy_q, done_q, illegal_q, bus_clr_q;
    logic [7:0]  sel_q, hold_q;

    logic start_ok, accept_ok, tmr_load, expired, is_clear;

    assign is_clear  = (instr[2:0] == instr[5:3]);
    assign start_ok  = start && (instr[7:6] == OP_MOV8);
    assign accept_ok = start_ok && (state_q == ST_IDLE || state_q == ST_DONE);
    // Reload on entry to each timed phase; LATCH exit needs no reload.
    assign tmr_load  = accept_ok ||
                       (expired && (state_q == ST_SELECT || state_q == ST_OPEN));

    phase_timer #(.W(4)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (tmr_load),
        .value   (SETTLE_LD),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            dst_q     <= REG_A;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            sel_q     <= '0;
            hold_q    <= '1;
            bus_clr_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    state_q <= ST_IDLE;
                    if (start) begin
                        if (instr[7:6] == OP_MOV8) begin
                            state_q   <= ST_SELECT;
                            dst_q     <= reg_code_e'(instr[5:3]);
                            busy_q    <= 1'b1;
                            sel_q     <= is_clear ? '0 : onehot8(reg_code_e'(instr[2:0]));
                            bus_clr_q <= is_clear;
                        end else begin
                            illegal_q <= 1'b1;
                        end
                    end
                end
                ST_SELECT: if (expired) begin
                    state_q <= ST_OPEN;
                    hold_q  <= ~onehot8(dst_q);
                end
                ST_OPEN: if (expired) begin
                    state_q <= ST_LATCH;
                    hold_q  <= '1;
                end
                ST_LATCH: if (expired) begin
                    state_q   <= ST_RELEASE;
                    sel_q     <= '0;
                    bus_clr_q <= 1'b0;
                end
                ST_RELEASE: begin
                    state_q <= ST_DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign illegal = illegal_q;
    assign sel     = sel_q;
    assign hold    = hold_q;
    assign bus_clr = bus_clr_q;

endmodule

// File: tb/tb_mov8_sequencer.sv
// Directed bench for mov8_sequencer with a simple register-file model on the bus.
module tb_mov8_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] instr;
    logic       busy, done, illegal, bus_clr;
    logic [7:0] sel, hold;

    int checks = 0;
    int errors = 0;

    logic [7:0] regs [8];
    logic [7:0] bus;

    logic [7:0] tr_sel  [20];
    logic [7:0] tr_hold [20];
    logic       tr_busy [20];
    logic       tr_done [20];
    logic       tr_ill  [20];
    logic       tr_clr  [20];

    mov8_sequencer #(.SETTLE(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .instr   (instr),
        .busy    (busy),
        .done    (done),
        .illegal (illegal),
        .sel     (sel),
        .hold    (hold),
        .bus_clr (bus_clr)
    );

    always #5 clk = ~clk;

    always_comb begin
        bus = 8'h00;
        if (!bus_clr) begin
            for (int n = 0; n < 8; n++) begin
                if (sel[n]) bus = bus | regs[n];
            end
        end
    end

    always @(posedge clk) begin
        for (int n = 0; n < 8; n++) begin
            if (!hold[n]) regs[n] <= bus;
        end
    end

    always @(negedge clk) begin
        checks++;
        if ($countones(sel) > 1 || (sel != 8'h00 && bus_clr) || $countones(~hold) > 1 ||
            ((~hold) != 8'h00 && sel == 8'h00 && !bus_clr)) begin
            errors++;
            $display("FAIL invariant t=%0t sel=%h bus_clr=%b hold=%h", $time, sel, bus_clr, hold);
        end
    end

    task automatic run_trace(input logic [7:0] i0, input int k2, input logic [7:0] i2,
                             input int k3, input logic [7:0] i3);
        for (int k = 0; k < 20; k++) begin
            tr_sel[k]  = sel;
            tr_hold[k] = hold;
            tr_busy[k] = busy;
            tr_done[k] = done;
            tr_ill[k]  = illegal;
            tr_clr[k]  = bus_clr;
            if (k == 0)       begin start = 1'b1; instr = i0; end
            else if (k == k2) begin start = 1'b1; instr = i2; end
            else if (k == k3) begin start = 1'b1; instr = i3; end
            else              begin start = 1'b0; instr = 8'h00; end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        start = 1'b0;
        instr = 8'h00;
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags busy=%b done=%b illegal=%b required 0 0 0", busy, done, illegal);
        end
        checks++;
        if (sel !== 8'h00 || hold !== 8'hFF || bus_clr !== 1'b0) begin
            errors++;
            $display("FAIL reset_lines sel=%h hold=%h bus_clr=%b required 00 ff 0", sel, hold, bus_clr);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL idle_busy cycle=%0d got=%b required=0", k, busy);
            end
        end
    endtask

    task automatic test_move_b_a();
        logic [7:0] exp_sel, exp_hold;
        regs[0] = 8'h5A;
        regs[1] = 8'hC3;
        run_trace(8'h08, -1, 8'h00, -1, 8'h00);
        for (int k = 1; k <= 10; k++) begin
            exp_sel  = (k <= 6) ? 8'h01 : 8'h00;
            exp_hold = (k == 3 || k == 4) ? 8'hFD : 8'hFF;
            checks++;
            if (tr_sel[k] !== exp_sel || tr_hold[k] !== exp_hold || tr_clr[k] !== 1'b0) begin
                errors++;
                $display("FAIL mov_ba_lines k=%0d sel=%h hold=%h clr=%b required %h %h 0",
                         k, tr_sel[k], tr_hold[k], tr_clr[k], exp_sel, exp_hold);
            end
            checks++;
            if (tr_done[k] !== (k == 8) || tr_busy[k] !== (k <= 7)) begin
                errors++;
                $display("FAIL mov_ba_flags k=%0d done=%b busy=%b required %b %b",
                         k, tr_done[k], tr_busy[k], k == 8, k <= 7);
            end
        end
        checks++;
        if (regs[1] !== 8'h5A || regs[0] !== 8'h5A) begin
            errors++;
            $display("FAIL mov_ba_data B=%h A=%h required 5a 5a", regs[1], regs[0]);
        end
    endtask

    task automatic test_clear_c();
        logic [7:0] exp_hold;
        regs[2] = 8'h77;
        run_trace(8'h12, -1, 8'h00, -1, 8'h00);
        for (int k = 1; k <= 9; k++) begin
            exp_hold = (k == 3 || k == 4) ? 8'hFB : 8'hFF;
            checks++;
            if (tr_clr[k] !== (k <= 6) || tr_sel[k] !== 8'h00 || tr_hold[k] !== exp_hold) begin
                errors++;
                $display("FAIL clear_lines k=%0d clr=%b sel=%h hold=%h required %b 00 %h",
                         k, tr_clr[k], tr_sel[k], tr_hold[k], k <= 6, exp_hold);
            end
        end
        checks++;
        if (tr_done[8] !== 1'b1) begin
            errors++;
            $display("FAIL clear_done got=%b required=1", tr_done[8]);
        end
        checks++;
        if (regs[2] !== 8'h00) begin
            errors++;
            $display("FAIL clear_data C=%h required=00", regs[2]);
        end
    endtask

    task automatic test_illegal();
        run_trace(8'h80, -1, 8'h00, -1, 8'h00);
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if (tr_ill[k] !== (k == 1)) begin
                errors++;
                $display("FAIL illegal_pulse k=%0d got=%b required=%b", k, tr_ill[k], k == 1);
            end
            checks++;
            if (tr_busy[k] !== 1'b0 || tr_sel[k] !== 8'h00 || tr_hold[k] !== 8'hFF || tr_done[k] !== 1'b0) begin
                errors++;
                $display("FAIL illegal_quiet k=%0d busy=%b sel=%h hold=%h done=%b required 0 00 ff 0",
                         k, tr_busy[k], tr_sel[k], tr_hold[k], tr_done[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        regs[0] = 8'h96;
        regs[1] = 8'h3C;
        regs[4] = 8'h00;
        regs[6] = 8'h00;
        // M1 <- B, ignored B <- C at N+4, then X <- A in the DONE cycle
        run_trace(8'h21, 4, 8'h0A, 8, 8'h30);
        for (int k = 1; k <= 17; k++) begin
            checks++;
            if (tr_ill[k] !== 1'b0 || tr_done[k] !== (k == 8 || k == 16)) begin
                errors++;
                $display("FAIL b2b_pulses k=%0d illegal=%b done=%b required 0 %b",
                         k, tr_ill[k], tr_done[k], k == 8 || k == 16);
            end
        end
        checks++;
        if (tr_sel[5] !== 8'h02 || tr_sel[6] !== 8'h02 || tr_hold[3] !== 8'hEF) begin
            errors++;
            $display("FAIL b2b_first sel5=%h sel6=%h hold3=%h required 02 02 ef",
                     tr_sel[5], tr_sel[6], tr_hold[3]);
        end
        checks++;
        if (tr_busy[8] !== 1'b0 || tr_busy[9] !== 1'b1 || tr_sel[9] !== 8'h01 || tr_hold[9] !== 8'hFF) begin
            errors++;
            $display("FAIL b2b_second_start busy8=%b busy9=%b sel9=%h hold9=%h required 0 1 01 ff",
                     tr_busy[8], tr_busy[9], tr_sel[9], tr_hold[9]);
        end
        checks++;
        if (tr_hold[11] !== 8'hBF || tr_hold[12] !== 8'hBF || tr_hold[13] !== 8'hFF) begin
            errors++;
            $display("FAIL b2b_second_hold h11=%h h12=%h h13=%h required bf bf ff",
                     tr_hold[11], tr_hold[12], tr_hold[13]);
        end
        checks++;
        if (regs[4] !== 8'h3C || regs[6] !== 8'h96 || regs[1] !== 8'h3C) begin
            errors++;
            $display("FAIL b2b_data M1=%h X=%h B=%h required 3c 96 3c", regs[4], regs[6], regs[1]);
        end
    endtask

    task automatic test_reset_mid_move();
        start = 1'b1;
        instr = 8'h08;
        @(negedge clk);
        start = 1'b0;
        instr = 8'h00;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (hold !== 8'hFD || sel !== 8'h01) begin
            errors++;
            $display("FAIL abort_open hold=%h sel=%h required fd 01", hold, sel);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (hold !== 8'hFF || sel !== 8'h00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_async hold=%h sel=%h busy=%b required ff 00 0", hold, sel, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || hold !== 8'hFF) begin
                errors++;
                $display("FAIL abort_idle cycle=%0d done=%b busy=%b hold=%h required 0 0 ff",
                         k, done, busy, hold);
            end
        end
    endtask

    initial begin
        for (int n = 0; n < 8; n++) regs[n] = 8'(8'h10 * n + n);
        test_reset();
        test_move_b_a();
        test_clear_c();
        test_illegal();
        test_back_to_back();
        test_reset_mid_move();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mov8_sequencer.md
# mov8_sequencer

Control sequencer for the 8-bit register-to-register move (MOV8) of the relay computer. It decodes a MOV8 instruction byte and drives the per-register `sel` (bus output enable) and `hold` (latch control) lines of the eight 8-bit registers A, B, C, D, M1, M2, X and Y. It sits directly upstream of the register units and steps them through select → open → latch → release. Each phase is stretched by a settle count so the bus is stable before any latch closes.

## Interface
- `SETTLE`, default 2: cycles spent in each of the SELECT, OPEN and LATCH phases; legal range 1..15.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `start`  in  1  request to execute `instr`; sampled only when the sequencer is idle.
- `instr`  in  8  instruction byte, encoded as 00dddsss; sampled together with `start`.
- `busy`  out  1  a move is in progress.
- `done`  out  1  one-cycle pulse when a move completes.
- `illegal`  out  1  one-cycle pulse when `start` is accepted with `instr[7:6] != 2'b00`.
- `sel`  out  8  one-hot source select; bit n drives register n onto the data bus.
- `hold`  out  8  per-register latch control; 1 = latched, 0 = transparent.
- `bus_clr`  out  1  drives 8'h00 onto the bus; used for the clear form of the move.

## Operation
- Register codes: 0=A, 1=B, 2=C, 3=D, 4=M1, 5=M2, 6=X, 7=Y. Source is `instr[2:0]`; destination is `instr[5:3]`.
- FSM states are IDLE, SELECT, OPEN, LATCH, RELEASE and DONE.
- **IDLE.** Outputs `sel=0`, `hold=8'hFF`, `bus_clr=0`.
  - On `start=1` with a legal opcode: capture src/dst, load the phase counter, go to SELECT.
  - On `start=1` with an illegal opcode: pulse `illegal` for the next cycle and stay in IDLE.
- **Clear form (src == dst).** `bus_clr=1` replaces `sel[src]` in SELECT, OPEN and LATCH, and `sel` stays 0. The destination therefore loads 8'h00.
- **SELECT.** Asserts `sel[src]` (or `bus_clr`). All `hold` bits stay 1. Lasts `SETTLE` cycles.
- **OPEN.** Keeps `sel[src]` (or `bus_clr`) and drives `hold[dst]=0`. Lasts `SETTLE` cycles.
- **LATCH.** Keeps `sel[src]` (or `bus_clr`) and drives `hold[dst]=1`, capturing the value. Lasts `SETTLE` cycles.
- **RELEASE.** Drives `sel=0` and `bus_clr=0`. Lasts 1 cycle.
- **DONE.** Asserts `done=1` and `busy=0`. Lasts 1 cycle, then returns to IDLE.
  - A `start` seen during DONE is accepted exactly as in IDLE, so moves can run back to back.
- **Invariants** (the bench asserts these every cycle):
  - At most one `sel` bit is high.
  - `sel` and `bus_clr` are never both nonzero.
  - At most one `hold` bit is 0.
  - A `hold` bit is 0 only while its source or `bus_clr` is driving.
- `start` while busy is ignored: it is not queued and produces no pulse.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Reset values: `busy=0`, `done=0`, `illegal=0`, `sel=8'h00`, `hold=8'hFF`, `bus_clr=0`, state IDLE, counter 0.
  - `rst_n` low mid-move forces these values immediately, without waiting for a clock edge.
  - Forcing `hold` to all 1s closes any open latch, so the destination keeps whatever value is on its latch. The interrupted move is not completed.
- Phase timeline, with N the cycle in which `start` is sampled:
  - SELECT: cycles N+1 .. N+S.
  - OPEN: cycles N+S+1 .. N+2S.
  - LATCH: cycles N+2S+1 .. N+3S.
  - RELEASE: cycle N+3S+1.
  - DONE: cycle N+3S+2.
- `busy` is high for cycles N+1 .. N+3S+1.
- With the default S=2, `done` arrives at N+8 and a move takes 8 cycles.
- `illegal` is asserted in cycle N+1 only, and `busy` stays 0.
- Phase counter: 4 bits, loaded with S−1 on phase entry, counts down; the phase advances when the counter is at 0.

## Structure
- Shared package `relay_pkg` holds:
  - `reg_code_e`, an 8-entry enum of the register codes above.
  - The `mov8_state_e` FSM enum.
  - Constant `OP_MOV8 = 2'b00`.
  - Function `onehot8(reg_code_e)`.
- Sub-module `phase_timer`: reloadable down-counter with a `load`/`value` input and an `expired` output. It is reused by later multi-phase sequencers.

## Test plan
- Reset: drive `rst_n=0` → all outputs at reset values. Release reset and hold `start=0` for 5 cycles → `busy` stays 0.
- Move B←A: `instr=8'h08`, S=2.
  - `sel=8'h01` during N+1..N+6.
  - `hold[1]=0` exactly during N+3..N+4.
  - `done` high at N+8.
  - With a Register model on the bus, B reads the value A holds (1 and 0 both checked).
- Clear C: `instr=8'h12`.
  - `bus_clr=1` during N+1..N+6 and `sel` stays 0.
  - `hold[2]=0` during N+3..N+4.
  - C reads 8'h00.
- Illegal opcode: `instr=8'h80` → `illegal` pulses at N+1; `busy`, `sel` and `hold` are unchanged.
- Back-to-back and busy:
  - A second `start` at N+4 is ignored.
  - A `start` at N+8 (the DONE cycle) is accepted, and the second move's SELECT begins at N+9.
- Reset mid-move: drive `rst_n` low during OPEN → `hold=8'hFF` and `sel=0` asynchronously. After reset releases, the sequencer is in IDLE and `done` never fires for the aborted move.
